// File: rtl/axis_mjr4_decimator.sv
// 4x-oversampled 1-bit stream to majority-decided bits with framing.
// Define AXIS_MJR4_STATS_EN to add the err_cnt non-unanimous group counter.
module axis_mjr4_decimator #(
    parameter int FRAME_LEN  = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_axis_tvalid,
    output logic s_axis_tready,
    input  logic s_axis_tdata,
    input  logic s_axis_tuser,
    input  logic s_axis_tlast,
    output logic m_axis_tvalid,
    input  logic m_axis_tready,
    output logic m_axis_tdata,
    output logic m_axis_tlast,
    output logic m_axis_tuser
`ifdef AXIS_MJR4_STATS_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_LEN);

    logic [1:0]            phase;
    logic [2:0]            sr;
    logic                  first_pending;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [FIFO_DEPTH-1:0] mem_bit;
    logic [FIFO_DEPTH-1:0] mem_first;
    logic [IW-1:0]         out_idx;

    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          decide;
    logic          pop;
    logic [2:0]    ones;
    logic          dec_bit;
    logic          head_bit;
    logic          head_first;
    logic [IW-1:0] cur_idx;
    logic          at_last;
    logic          unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Only the group-closing sample can stall; no bypass on simultaneous pop.
    assign s_axis_tready = !((phase == 2'd3) && fifo_full);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign decide        = accept && !s_axis_tuser && (phase == 2'd3);

    assign ones    = 3'(s_axis_tdata) + 3'(sr[0]) + 3'(sr[1]) + 3'(sr[2]);
    assign dec_bit = (ones >= 3'd3);

    assign head_bit   = mem_bit[rd_ptr[AW-1:0]];
    assign head_first = mem_first[rd_ptr[AW-1:0]];
    assign cur_idx    = head_first ? '0 : out_idx;
    assign at_last    = (cur_idx == IW'(FRAME_LEN - 1));

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid && head_bit;
    assign m_axis_tuser  = m_axis_tvalid && head_first;
    assign m_axis_tlast  = m_axis_tvalid && at_last;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase         <= 2'd0;
            sr            <= 3'd0;
            first_pending <= 1'b1;
        end else if (accept) begin
            sr <= {sr[1:0], s_axis_tdata};
            if (s_axis_tuser) begin
                phase         <= 2'd1;
                first_pending <= 1'b1;
            end else begin
                phase <= phase + 2'd1;
                if (phase == 2'd3)
                    first_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            mem_bit   <= '0;
            mem_first <= '0;
        end else if (decide) begin
            mem_bit[wr_ptr[AW-1:0]]   <= dec_bit;
            mem_first[wr_ptr[AW-1:0]] <= first_pending;
            wr_ptr                    <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            out_idx <= '0;
        end else if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            out_idx <= at_last ? '0 : cur_idx + IW'(1);
        end
    end

`ifdef AXIS_MJR4_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 16'd0;
        else if (decide && ones != 3'd0 && ones != 3'd4 &&
                 err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axis_mjr4_decimator.sv
// Bench for axis_mjr4_decimator: directed scenarios plus random traffic
// checked against a stream-level reference model.
module tb_axis_mjr4_decimator;

    localparam int FL = 13;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic s_axis_tdata = 1'b0;
    logic s_axis_tuser = 1'b0;
    logic s_axis_tlast = 1'b0;
    logic m_axis_tvalid;
    logic m_axis_tready = 1'b0;
    logic m_axis_tdata;
    logic m_axis_tlast;
    logic m_axis_tuser;
`ifdef AXIS_MJR4_STATS_EN
    logic [15:0] err_cnt;
`endif

    axis_mjr4_decimator #(.FRAME_LEN(FL), .FIFO_DEPTH(DP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser)
`ifdef AXIS_MJR4_STATS_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    ent_t fq[$];
    int   gcnt;
    int   gones;
    logic mfirst;
    int   since;
    int   mstats;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        fq.delete();
        gcnt   = 0;
        gones  = 0;
        mfirst = 1'b1;
        since  = 0;
        mstats = 0;
    endfunction

    function automatic logic exp_ready();
        return !(gcnt == 3 && fq.size() == DP);
    endfunction

    // Compare DUT outputs with the model, then drive one cycle of inputs.
    task automatic step(input logic v, input logic d, input logic u,
                        input logic mr, output logic acc);
        ent_t e;
        logic pop;
        @(negedge clk);
        check("s_tready", s_axis_tready, exp_ready());
        check("m_tvalid", m_axis_tvalid, fq.size() > 0);
        if (fq.size() > 0) begin
            check("m_tdata", m_axis_tdata, fq[0].b);
            check("m_tuser", m_axis_tuser, fq[0].f);
            check("m_tlast", m_axis_tlast, fq[0].l);
        end
`ifdef AXIS_MJR4_STATS_EN
        check("err_cnt", err_cnt, mstats);
`endif
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = 1'($urandom_range(0, 1));
        m_axis_tready = mr;
        acc = v && exp_ready();
        pop = mr && fq.size() > 0;
        if (pop)
            void'(fq.pop_front());
        if (acc) begin
            if (u) begin
                gcnt   = 1;
                gones  = int'(d);
                mfirst = 1'b1;
            end else begin
                gcnt++;
                gones += int'(d);
            end
            if (gcnt == 4) begin
                since = mfirst ? 0 : since + 1;
                e.b = (gones >= 3);
                e.f = mfirst;
                e.l = ((since % FL) == FL - 1);
                fq.push_back(e);
                if (gones != 0 && gones != 4)
                    mstats++;
                mfirst = 1'b0;
                gcnt   = 0;
                gones  = 0;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic feed(input logic d, input logic u, input logic mr);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++)
            step(1'b1, d, u, mr, acc);
        if (!acc)
            check("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed_group(input logic [3:0] g, input logic mr);
        for (int i = 3; i >= 0; i--)
            feed(g[i], 1'b0, mr);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && fq.size() > 0; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", fq.size(), 0);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    logic acc_r;
    int   nbits;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tready", s_axis_tready, 1);

        // 1: 1,1,0,1 decides 1 with first flag
        feed_group(4'b1101, 1'b0);
        @(negedge clk);
        check("t1_tdata", m_axis_tdata, 1);
        check("t1_tuser", m_axis_tuser, 1);
        check("t1_tlast", m_axis_tlast, 0);
        drain();

        // 2: ties decide 0
        feed_group(4'b1100, 1'b0);
        feed_group(4'b0011, 1'b0);
        @(negedge clk);
        check("t2_tdata", m_axis_tdata, 0);
        drain();

        // 3: 14 groups with sink always ready, framing realigned by resync
        feed(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            feed(1'b1, 1'b0, 1'b1);
        for (int g = 1; g < 14; g++)
            feed_group(4'($urandom), 1'b1);
        drain();

        // 4: backpressure with five groups
        for (int g = 0; g < 4; g++)
            feed_group(4'($urandom), 1'b0);
        for (int i = 0; i < 3; i++)
            feed(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, acc_r);
        check("t4_stall", s_axis_tready, 0);
        feed(1'b1, 1'b0, 1'b1);
        drain();

        // 5: resync after two samples
        feed(1'b1, 1'b0, 1'b0);
        feed(1'b0, 1'b0, 1'b0);
        feed(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            feed(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_tuser", m_axis_tuser, 1);
        check("t5_tdata", m_axis_tdata, 1);
        for (int g = 0; g < 14; g++)
            feed_group(4'($urandom), 1'b1);
        drain();

        // 6: async reset with three entries stored
        feed_group(4'b0111, 1'b0);
        feed_group(4'b0001, 1'b0);
        feed_group(4'b1111, 1'b0);
        feed(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_tready", s_axis_tready, 1);
`ifdef AXIS_MJR4_STATS_EN
        check("t6_err_cnt", err_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        feed_group(4'b1110, 1'b0);
        @(negedge clk);
        check("t6_tuser", m_axis_tuser, 1);
        drain();

        // Random traffic
        nbits = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 2) != 0), acc_r);
            if (acc_r)
                nbits++;
        end
        check("rand_activity", nbits > 500, 1);
        drain();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
